// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with valid/ready handshake and optional 2-entry skid buffer
module pipe_stage_elastic #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int                SKID      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t            state;
   logic [DATA_W-1:0] main;
   logic [DATA_W-1:0] skid;
   logic              rdy_q;
   logic              in_fire;
   logic              out_fire;
   assign out_valid = state != EMPTY;
   assign out_data  = main;
   assign occupancy = state;
   assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // State, data registers and registered ready; flush overrides every handshake
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= EMPTY;
         main  <= RESET_VAL;
         skid  <= RESET_VAL;
         rdy_q <= 1'b1;
      end else if (flush) begin
         state <= EMPTY;
         main  <= RESET_VAL;
         skid  <= RESET_VAL;
         rdy_q <= 1'b1;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               main  <= in_data;
               state <= ONE;
            end
            ONE: if (in_fire) begin
               if (out_fire) main <= in_data;
               else if (SKID != 0) begin
                  skid  <= in_data;
                  state <= TWO;
               end
            end else if (out_fire) state <= EMPTY;
            TWO: if (out_fire) begin
               main  <= skid;
               state <= ONE;
            end
            default: state <= EMPTY;
         endcase
         rdy_q <= !((state == ONE && in_fire && !out_fire) || (state == TWO && !out_fire));
      end
endmodule
